avl_vlb_arbiter2: RTL and testbench
===================================

# avl_vlb_arbiter2

Two-port arbiter sharing one Avalon-MM variable-length-burst memory slave between two Avalon-MM masters, e.g. the write and read engines of the packet-stream burst buffer. Grants are burst-locked: a write burst holds the shared port until its last beat is accepted, and a read burst holds it only for its command cycle. Read responses are routed back to their issuing port through an in-order tracking FIFO, so several reads can be in flight.

## Interface
- DWIDTH, 8, data width
- AWIDTH, 8, address width
- BWIDTH, 8, burstcount width; legal burstcount is 1..2**(BWIDTH-1)
- MAXPENDING, 4, depth of the read-tracking FIFO (maximum outstanding read bursts); power of two, ≥2
- reset  in  1  asynchronous, active-high reset
- clk  in  1  single clock; all logic on its rising edge
- avsN_address  in  AWIDTH  port N address (N = 0, 1)
- avsN_burstcount  in  BWIDTH  port N burst length
- avsN_write / avsN_read  in  1  port N requests
- avsN_writedata  in  DWIDTH  port N write data
- avsN_readdata  out  DWIDTH  shared read data, driven to both ports
- avsN_readdatavalid  out  1  read beat for port N
- avsN_waitrequest  out  1  port N stall
- avm_address, avm_burstcount, avm_write, avm_writedata, avm_read  out  —  shared master command
- avm_readdata  in  DWIDTH; avm_readdatavalid  in  1; avm_waitrequest  in  1

## Operation
- States: IDLE, CMD, WBURST. Registered grant `gnt` (0/1), round-robin pointer `last`, beat counter `beats` (BWIDTH bits).
- IDLE: avm_read = avm_write = 0; both avsN_waitrequest = 1. If reqN = avsN_read | avsN_write on one port only, that port is granted. If both ports request, the port ≠ `last` is granted. Next state is CMD.
- CMD: avm_* = avs[gnt]_* (combinational mux). avs[gnt]_waitrequest = avm_waitrequest | (avs[gnt]_read & fifo_full). While fifo_full, avm_read is forced to 0. The non-granted port's waitrequest stays 1.
- Command acceptance (request high and waitrequest low) in CMD:
  - Read: push {gnt, burstcount} into the FIFO; `last` ← gnt; go to IDLE.
  - Write with burstcount = 1: `last` ← gnt; go to IDLE.
  - Write with burstcount > 1: `beats` ← burstcount−1; go to WBURST.
- WBURST: write path muxed as in CMD and avm_read forced to 0. Each accepted beat decrements `beats`. The beat accepted with `beats` = 1 sets `last` ← gnt and returns to IDLE. A read on the granted port during WBURST is ignored (avm_read stays 0).
- Burstcount 0 is treated as 1.
- Read return: avsN_readdata = avm_readdata. avs[head.id]_readdatavalid = avm_readdatavalid when the FIFO is non-empty. The head count decrements per valid beat; the entry pops on its last beat.
- avm_readdatavalid with an empty FIFO is dropped; no port sees it.
- Push and pop in the same cycle are both performed. Push is refused whenever the FIFO is full, even if a pop occurs in that cycle.

## Timing
- Reset (asynchronous, immediate): state IDLE, `last` = 1 (port 0 wins the first tie), FIFO empty.
- Output values during reset: avm_read = avm_write = 0; avsN_waitrequest = 1; avsN_readdatavalid = 0.
- Reset during a burst abandons the burst and discards in-flight read tracking.
- Grant latency: a request sampled in IDLE at edge k appears on avm_* in the cycle after edge k, i.e. one bubble cycle per grant.
- Write-burst beats and read-return beats pass combinationally, with zero added latency.
- Minimum spacing of consecutive granted commands: 2 cycles.

## Configuration
- AVL_VLB_ARBITER_FIXPRIO_EN defined: fixed priority. Port 0 wins every tie and `last` is unused.
- AVL_VLB_ARBITER_FIXPRIO_EN undefined (default): round-robin as above.

## Test plan
- Single port 0 write, burst 4, addr 0x10, slave waitrequest random: exactly 4 beats reach the slave at 0x10..0x13; port 1 waitrequest stays 1 throughout.
- Both ports request reads of burst 2 simultaneously after reset: port 0 is granted first, then port 1. Port 0 sees 2 valid beats, then port 1 sees 2; no cross-routing.
- Port 1 write burst 8 in progress while port 0 requests: port 0 is held until the 8th beat is accepted, then granted after one bubble.
- MAXPENDING = 4, slave latency 20: 5 back-to-back reads from port 0. The 5th command is stalled (waitrequest = 1) until the first burst fully returns.
- Reset asserted mid write burst (beat 3 of 6): outputs return to their reset values immediately; a new request after release is granted normally.
- With AVL_VLB_ARBITER_FIXPRIO_EN: both ports continuously requesting single writes means port 0 is granted every time.

Source files
------------

// File: rtl/avl_vlb_arbiter2_if.sv
// ---------------------------------------------------------------------------
// avl_vlb_arbiter2_if
//
// Avalon-MM variable-length-burst bus bundle used by avl_vlb_arbiter2.
//
// Modports:
//   master : the side that issues commands
//            (drives address/burstcount/write/read/writedata,
//             receives readdata/readdatavalid/waitrequest)
//   slave  : the side that accepts commands (mirror of master)
//
// Parameters:
//   DWIDTH  data width
//   AWIDTH  address width
//   BWIDTH  burstcount width
// ---------------------------------------------------------------------------
interface avl_vlb_arbiter2_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8,
  parameter int BWIDTH = 8
);
  logic [AWIDTH-1:0] address;
  logic [BWIDTH-1:0] burstcount;
  logic              write;
  logic              read;
  logic [DWIDTH-1:0] writedata;
  logic [DWIDTH-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address, burstcount, write, read, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, burstcount, write, read, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/avl_vlb_arbiter2.sv
// ---------------------------------------------------------------------------
// avl_vlb_arbiter2
//
// Shares one Avalon-MM variable-length-burst slave between two Avalon-MM
// masters. Grants are burst-locked: a write burst owns the shared port until
// its last beat is accepted, a read burst owns it only for its command cycle.
// Read responses are steered back to the issuing port through an in-order
// tracking FIFO, so up to MAXPENDING read bursts can be outstanding.
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   asynchronous, active-high reset
//   avs0   slave modport  - upstream port 0 (command in, response out)
//   avs1   slave modport  - upstream port 1 (command in, response out)
//   avm    master modport - shared downstream command/response
//
// Parameters:
//   DWIDTH      data width
//   AWIDTH      address width
//   BWIDTH      burstcount width (legal burstcount 1..2**(BWIDTH-1))
//   MAXPENDING  read-tracking FIFO depth, power of two, >= 2
//
// Configuration macro:
//   AVL_VLB_ARBITER_FIXPRIO_EN  defined   -> port 0 wins every tie
//                               undefined -> round-robin on ties (default)
// ---------------------------------------------------------------------------
module avl_vlb_arbiter2 #(
  parameter int DWIDTH     = 8,
  parameter int AWIDTH     = 8,
  parameter int BWIDTH     = 8,
  parameter int MAXPENDING = 4
) (
  input  logic               clk,
  input  logic               reset,
  avl_vlb_arbiter2_if.slave  avs0,
  avl_vlb_arbiter2_if.slave  avs1,
  avl_vlb_arbiter2_if.master avm
);

  localparam int PW = $clog2(MAXPENDING);

  typedef enum logic [1:0] {IDLE, CMD, WBURST} state_t;

  // Arbitration state
  state_t            r_state;
  logic              r_gnt;
  logic [BWIDTH-1:0] r_beats;

  // Read-tracking FIFO: pointers carry one extra wrap bit for full/empty
  logic [PW:0]       r_wp;
  logic [PW:0]       r_rp;
  logic [BWIDTH-1:0] r_rcnt;
  logic              r_fid  [MAXPENDING];
  logic [BWIDTH-1:0] r_fcnt [MAXPENDING];

  logic              w_req0;
  logic              w_req1;
  logic              w_tie_gnt;
  logic              w_nxt_gnt;
  logic [AWIDTH-1:0] w_sel_addr;
  logic [BWIDTH-1:0] w_sel_bc;
  logic [BWIDTH-1:0] w_bc_eff;
  logic [DWIDTH-1:0] w_sel_wdata;
  logic              w_sel_read;
  logic              w_sel_write;
  logic              w_full;
  logic              w_empty;
  logic              w_avm_read;
  logic              w_avm_write;
  logic              w_wait_g;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_last_beat;
  logic              w_done;
  logic              w_head_id;
  logic [BWIDTH-1:0] w_head_cnt;
  logic              w_rdv;
  logic              w_pop;
  logic              w_push;

  assign w_req0 = avs0.read | avs0.write;
  assign w_req1 = avs1.read | avs1.write;

  // Tie-break source. In fixed-priority builds the round-robin pointer does
  // not exist at all.
`ifdef AVL_VLB_ARBITER_FIXPRIO_EN
  assign w_tie_gnt = 1'b0;
`else
  logic r_last;

  // Points at the port that most recently completed a command; resets to 1
  // so port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (w_done) begin
      r_last <= r_gnt;
    end
  end

  assign w_tie_gnt = ~r_last;
`endif

  assign w_nxt_gnt = (w_req0 & w_req1) ? w_tie_gnt : w_req1;

  // Command path mux, selected by the registered grant
  assign w_sel_addr  = r_gnt ? avs1.address    : avs0.address;
  assign w_sel_bc    = r_gnt ? avs1.burstcount : avs0.burstcount;
  assign w_sel_wdata = r_gnt ? avs1.writedata  : avs0.writedata;
  assign w_sel_read  = r_gnt ? avs1.read       : avs0.read;
  assign w_sel_write = r_gnt ? avs1.write      : avs0.write;

  // A burstcount of 0 behaves as a single beat
  assign w_bc_eff = (w_sel_bc == '0) ? BWIDTH'(1) : w_sel_bc;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);

  // Command qualification. A read wins over a simultaneous write on the
  // granted port in CMD so the slave never sees both strobes; reads are
  // blocked while the tracking FIFO has no room, and ignored inside a write
  // burst.
  always_comb begin
    w_avm_read  = 1'b0;
    w_avm_write = 1'b0;
    w_wait_g    = 1'b1;
    w_rd_acc    = 1'b0;
    w_wr_acc    = 1'b0;
    case (r_state)
      CMD: begin
        w_avm_read  = w_sel_read & ~w_full;
        w_avm_write = w_sel_write & ~w_sel_read;
        w_wait_g    = avm.waitrequest | (w_sel_read & w_full);
        w_rd_acc    = w_avm_read & ~avm.waitrequest;
        w_wr_acc    = w_avm_write & ~avm.waitrequest;
      end
      WBURST: begin
        w_avm_write = w_sel_write;
        w_wait_g    = avm.waitrequest;
        w_wr_acc    = w_sel_write & ~avm.waitrequest;
      end
      default: begin
      end
    endcase
  end

  // In CMD the last beat is a single-beat write; in WBURST it is the beat
  // seen with one beat remaining.
  assign w_last_beat = (r_state == CMD) ? (w_bc_eff == BWIDTH'(1))
                                        : (r_beats == BWIDTH'(1));
  assign w_done      = w_rd_acc | (w_wr_acc & w_last_beat);

  // Shared command outputs
  assign avm.address    = w_sel_addr;
  assign avm.burstcount = w_sel_bc;
  assign avm.writedata  = w_sel_wdata;
  assign avm.read       = w_avm_read;
  assign avm.write      = w_avm_write;

  // Only the granted port ever sees waitrequest low
  assign avs0.waitrequest = r_gnt ? 1'b1     : w_wait_g;
  assign avs1.waitrequest = r_gnt ? w_wait_g : 1'b1;

  // --- Arbitration FSM ---
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt   <= 1'b0;
      r_beats <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req0 | w_req1) begin
            r_gnt   <= w_nxt_gnt;
            r_state <= CMD;
          end
        end
        CMD: begin
          if (w_rd_acc) begin
            r_state <= IDLE;
          end else if (w_wr_acc) begin
            if (w_last_beat) begin
              r_state <= IDLE;
            end else begin
              r_beats <= w_bc_eff - BWIDTH'(1);
              r_state <= WBURST;
            end
          end
        end
        WBURST: begin
          if (w_wr_acc) begin
            if (w_last_beat) begin
              r_state <= IDLE;
            end else begin
              r_beats <= r_beats - BWIDTH'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // --- Read return routing ---
  assign w_head_id  = r_fid[r_rp[PW-1:0]];
  assign w_head_cnt = r_fcnt[r_rp[PW-1:0]];

  // Beats arriving with nothing outstanding are dropped
  assign w_rdv  = avm.readdatavalid & ~w_empty;
  assign w_pop  = w_rdv & ((r_rcnt + BWIDTH'(1)) == w_head_cnt);
  assign w_push = w_rd_acc;

  assign avs0.readdata      = avm.readdata;
  assign avs1.readdata      = avm.readdata;
  assign avs0.readdatavalid = w_rdv & ~w_head_id;
  assign avs1.readdatavalid = w_rdv &  w_head_id;

  // FIFO control; push is already suppressed when full, so push and pop in
  // the same cycle only happen with room to spare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_rcnt <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp   <= r_rp + 1'b1;
        r_rcnt <= '0;
      end else if (w_rdv) begin
        r_rcnt <= r_rcnt + BWIDTH'(1);
      end
    end
  end

  // FIFO storage: contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fid[r_wp[PW-1:0]]  <= r_gnt;
      r_fcnt[r_wp[PW-1:0]] <= w_bc_eff;
    end
  end

endmodule

// File: tb/tb_avl_vlb_arbiter2.sv
// ---------------------------------------------------------------------------
// tb_avl_vlb_arbiter2
//
// Directed bench for avl_vlb_arbiter2 with a small behavioural memory slave
// (programmable read latency, optional random waitrequest) and a response
// monitor. Expected values are hand-derived constants and tables.
// ---------------------------------------------------------------------------
module tb_avl_vlb_arbiter2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  avl_vlb_arbiter2_if #(.DWIDTH(8), .AWIDTH(8), .BWIDTH(8)) avs0_if ();
  avl_vlb_arbiter2_if #(.DWIDTH(8), .AWIDTH(8), .BWIDTH(8)) avs1_if ();
  avl_vlb_arbiter2_if #(.DWIDTH(8), .AWIDTH(8), .BWIDTH(8)) avm_if ();

  avl_vlb_arbiter2 #(
    .DWIDTH(8), .AWIDTH(8), .BWIDTH(8), .MAXPENDING(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .avs0  (avs0_if),
    .avs1  (avs1_if),
    .avm   (avm_if)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int lat    = 2;
  bit wr_rand = 1'b0;

  typedef struct {
    int         due;
    logic [7:0] addr;
    int         len;
  } rq_t;

  rq_t        rq[$];
  int         rbeat = 0;
  int         wbeat = 0;
  int         wlen  = 1;
  logic [7:0] wbase = 8'h00;

  logic [7:0] cap_addr[$];
  logic [7:0] cap_data[$];
  int         cap_cyc[$];
  logic [7:0] rd0_q[$];
  logic [7:0] rd1_q[$];
  int         rd0_cyc[$];
  int         seq[$];
  bit         both_rdv = 1'b0;
  bit         mon_w1   = 1'b0;
  bit         w1_low   = 1'b0;

  bit ok0, ok1;
  int ac0, ac1;
  int acc5[5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] qat(input logic [7:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 8'hxx;
  endfunction

  function automatic int qcy(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -999;
  endfunction

  // Memory slave: acceptance decided on the falling edge (inputs are stable
  // there), response/waitrequest updated just after the rising edge.
  initial begin
    avm_if.waitrequest   = 1'b0;
    avm_if.readdatavalid = 1'b0;
    avm_if.readdata      = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        wbeat = 0;
        rbeat = 0;
        rq.delete();
      end else begin
        if (avm_if.write && !avm_if.waitrequest) begin
          if (wbeat == 0) begin
            wbase = avm_if.address;
            wlen  = (avm_if.burstcount == 8'h00) ? 1 : int'(avm_if.burstcount);
          end
          cap_addr.push_back(wbase + 8'(wbeat));
          cap_data.push_back(avm_if.writedata);
          cap_cyc.push_back(cyc);
          wbeat++;
          if (wbeat >= wlen) wbeat = 0;
        end
        if (avm_if.read && !avm_if.waitrequest)
          rq.push_back('{cyc + lat, avm_if.address,
                         (avm_if.burstcount == 8'h00) ? 1 : int'(avm_if.burstcount)});
      end
      @(posedge clk);
      #1;
      cyc++;
      avm_if.readdatavalid = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        avm_if.readdatavalid = 1'b1;
        avm_if.readdata      = rq[0].addr + 8'(rbeat);
        rbeat++;
        if (rbeat >= rq[0].len) begin
          rbeat = 0;
          void'(rq.pop_front());
        end
      end
      avm_if.waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (avs0_if.readdatavalid) begin
        rd0_q.push_back(avs0_if.readdata);
        rd0_cyc.push_back(cyc);
        seq.push_back(0);
      end
      if (avs1_if.readdatavalid) begin
        rd1_q.push_back(avs1_if.readdata);
        seq.push_back(1);
      end
      if (avs0_if.readdatavalid && avs1_if.readdatavalid) both_rdv = 1'b1;
      if (mon_w1 && !avs1_if.waitrequest) w1_low = 1'b1;
    end
  end

  task automatic drive(input int p, input logic rd, input logic wr, input logic [7:0] a,
                       input logic [7:0] bc, input logic [7:0] d);
    if (p == 0) begin
      avs0_if.read = rd; avs0_if.write = wr; avs0_if.address = a;
      avs0_if.burstcount = bc; avs0_if.writedata = d;
    end else begin
      avs1_if.read = rd; avs1_if.write = wr; avs1_if.address = a;
      avs1_if.burstcount = bc; avs1_if.writedata = d;
    end
  endtask

  function automatic logic wt(input int p);
    return (p == 0) ? avs0_if.waitrequest : avs1_if.waitrequest;
  endfunction

  // Issue one command (read) or nbeats write beats of a len-beat burst.
  // acc returns the slave cycle number at which the last beat was accepted.
  task automatic m_xfer(input int p, input bit rd, input logic [7:0] a, input int len,
                        input logic [7:0] d0, input int nbeats, output bit ok, output int acc);
    int nb;
    nb  = rd ? 1 : nbeats;
    ok  = 1'b1;
    acc = -1;
    for (int b = 0; b < nb; b++) begin
      int n;
      n = 0;
      drive(p, rd, !rd, a, 8'(len), d0 + 8'(b));
      do begin
        @(negedge clk);
        n++;
      end while (wt(p) && n < 300);
      if (wt(p)) begin
        ok = 1'b0;
        drive(p, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        return;
      end
      acc = cyc;
      @(posedge clk);
      #1;
    end
    drive(p, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp6[6];
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;

    // Outputs while reset is held
    check("rst_avm_write", avm_if.write, 0);
    check("rst_avm_read", avm_if.read, 0);
    check("rst_avs0_wait", avs0_if.waitrequest, 1);
    check("rst_avs1_wait", avs1_if.waitrequest, 1);
    check("rst_avs0_rdv", avs0_if.readdatavalid, 0);
    check("rst_avs1_rdv", avs1_if.readdatavalid, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Port 0 write burst 4 @0x10 against a randomly stalling slave
    wr_rand = 1'b1;
    mon_w1  = 1'b1;
    cap_addr.delete(); cap_data.delete(); cap_cyc.delete();
    m_xfer(0, 1'b0, 8'h10, 4, 8'h40, 4, ok0, ac0);
    check("t1_complete", ok0, 1);
    repeat (3) @(posedge clk);
    #1;
    mon_w1  = 1'b0;
    wr_rand = 1'b0;
    check("t1_beat_count", cap_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_addr%0d", i), qat(cap_addr, i), 8'h10 + 8'(i));
      check($sformatf("t1_data%0d", i), qat(cap_data, i), 8'h40 + 8'(i));
    end
    check("t1_p1_wait_low_seen", w1_low, 0);
    repeat (2) @(posedge clk);

    // Stray readdatavalid with nothing outstanding must reach no port
    @(posedge clk);
    #2;
    avm_if.readdatavalid = 1'b1;
    #1;
    check("drop_rdv0", avs0_if.readdatavalid, 0);
    check("drop_rdv1", avs1_if.readdatavalid, 0);
    #1;
    avm_if.readdatavalid = 1'b0;

    // Simultaneous reads of burst 2 right after reset: port 0 first
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    lat = 3;
    rd0_q.delete(); rd1_q.delete(); rd0_cyc.delete(); seq.delete();
    both_rdv = 1'b0;
    fork
      m_xfer(0, 1'b1, 8'h20, 2, 8'h00, 1, ok0, ac0);
      m_xfer(1, 1'b1, 8'h30, 2, 8'h00, 1, ok1, ac1);
    join
    repeat (12) @(posedge clk);
    #1;
    check("t2_p0_complete", ok0, 1);
    check("t2_p1_complete", ok1, 1);
    check("t2_p0_granted_first", (ac0 < ac1), 1);
    check("t2_p0_beats", rd0_q.size(), 2);
    check("t2_p1_beats", rd1_q.size(), 2);
    check("t2_p0_d0", qat(rd0_q, 0), 8'h20);
    check("t2_p0_d1", qat(rd0_q, 1), 8'h21);
    check("t2_p1_d0", qat(rd1_q, 0), 8'h30);
    check("t2_p1_d1", qat(rd1_q, 1), 8'h31);
    check("t2_order", {seq.size() == 4, (seq.size() == 4) ? {seq[0][0], seq[1][0], seq[2][0], seq[3][0]} : 4'hf},
          {1'b1, 4'b0011});
    check("t2_cross_route", both_rdv, 0);

    // Port 1 write burst 8 holds off a port 0 request; one bubble after
    cap_addr.delete(); cap_data.delete(); cap_cyc.delete();
    fork
      m_xfer(1, 1'b0, 8'h50, 8, 8'h60, 8, ok1, ac1);
      begin
        repeat (3) @(posedge clk);
        #1;
        m_xfer(0, 1'b0, 8'h60, 1, 8'h99, 1, ok0, ac0);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    check("t3_p1_complete", ok1, 1);
    check("t3_p0_complete", ok0, 1);
    check("t3_beat_count", cap_addr.size(), 9);
    for (int i = 0; i < 8; i++)
      check($sformatf("t3_p1_addr%0d", i), qat(cap_addr, i), 8'h50 + 8'(i));
    check("t3_p0_addr", qat(cap_addr, 8), 8'h60);
    check("t3_p0_data", qat(cap_data, 8), 8'h99);
    check("t3_bubble", qcy(cap_cyc, 8) - qcy(cap_cyc, 7), 2);

    // Five back-to-back reads, latency 20: the fifth waits for the first pop
    lat = 20;
    rd0_q.delete(); rd1_q.delete(); rd0_cyc.delete(); seq.delete();
    for (int k = 0; k < 5; k++) begin
      m_xfer(0, 1'b1, 8'h80 + 8'(2 * k), 2, 8'h00, 1, ok0, acc5[k]);
      check($sformatf("t4_cmd%0d_complete", k), ok0, 1);
    end
    repeat (50) @(posedge clk);
    #1;
    check("t4_back_to_back", acc5[3] - acc5[0], 6);
    check("t4_p0_beats", rd0_q.size(), 10);
    check("t4_p1_beats", rd1_q.size(), 0);
    for (int i = 0; i < 10; i++)
      check($sformatf("t4_d%0d", i), qat(rd0_q, i), 8'h80 + 8'(i));
    check("t4_fifth_after_pop", acc5[4], qcy(rd0_cyc, 1) + 1);
    lat = 2;

    // Reset during beat 3 of a 6-beat write burst
    cap_addr.delete(); cap_data.delete(); cap_cyc.delete();
    m_xfer(0, 1'b0, 8'h70, 6, 8'hC0, 2, ok0, ac0);
    drive(0, 1'b0, 1'b1, 8'h70, 8'd6, 8'hC2);
    #2;
    check("t5_beat3_on_bus", avm_if.write, 1);
    reset = 1'b1;
    #1;
    check("t5_rst_avm_write", avm_if.write, 0);
    check("t5_rst_avm_read", avm_if.read, 0);
    check("t5_rst_avs0_wait", avs0_if.waitrequest, 1);
    check("t5_rst_avs1_wait", avs1_if.waitrequest, 1);
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t5_beats_before_reset", cap_addr.size(), 2);
    m_xfer(1, 1'b0, 8'h90, 1, 8'h55, 1, ok1, ac1);
    @(posedge clk);
    #1;
    check("t5_after_release_complete", ok1, 1);
    check("t5_after_release_addr", qat(cap_addr, 2), 8'h90);
    check("t5_after_release_data", qat(cap_data, 2), 8'h55);

    // Both ports streaming single writes
    cap_addr.delete(); cap_data.delete(); cap_cyc.delete();
    fork
      begin
        bit okl; int acl;
        for (int k = 0; k < 3; k++) m_xfer(0, 1'b0, 8'hA0 + 8'(k), 1, 8'(k), 1, okl, acl);
      end
      begin
        bit okl; int acl;
        for (int k = 0; k < 3; k++) m_xfer(1, 1'b0, 8'hB0 + 8'(k), 1, 8'(k), 1, okl, acl);
      end
    join
    repeat (2) @(posedge clk);
    #1;
`ifdef AVL_VLB_ARBITER_FIXPRIO_EN
    exp6 = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
`else
    exp6 = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
`endif
    check("t6_count", cap_addr.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t6_grant%0d", i), qat(cap_addr, i), exp6[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
